load_store_unit32: RTL and testbench
====================================

LOAD_STORE_UNIT32 -- requirements
Module: load_store_unit32

Interface
REQ-001 SHALL have parameter n, default 32, data and address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  core presents an access.
REQ-005 SHALL have port req_ready  output  1  unit can accept an access.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  n  byte address.
REQ-009 SHALL have port req_wdata  input  n  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  n  load result, extended.
REQ-012 SHALL have port resp_error  output  1  misaligned or illegal access.
REQ-013 SHALL have port mem_write_enable  output  1  word write strobe to data memory.
REQ-014 SHALL have port mem_addr  output  n  word index: {2'b00, addr[n-1:2]}.
REQ-015 SHALL have port mem_write_data  output  n  full word to write.
REQ-016 SHALL have port mem_read_data  input  n  combinational word read of mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept on req_valid && req_ready in cycle T and latch we, funct3, addr and wdata.
REQ-019 SHALL flag an error when: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011, 110 or 111; store with funct3 100 or 101.
REQ-020 SHALL, on an error access, go IDLE->RESP, with resp_valid at T+1, resp_error=1, resp_rdata=0, and no memory write.
REQ-021 SHALL, for a load, go IDLE->READ->RESP, capture mem_read_data at the end of READ, and pulse resp_valid at T+2.
REQ-022 SHALL extract the load lane at byte offset addr[1:0] (bits 8*k+7:8*k) or halfword offset addr[1] (bits 16*h+15:16*h).
REQ-023 SHALL sign-extend B/H loads and zero-extend BU/HU loads.
REQ-024 SHALL, for a SW store, go IDLE->WRITE->RESP, with mem_write_enable=1 in T+1, mem_write_data=wdata, and resp_valid at T+2.
REQ-025 SHALL, for an SB/SH store, go IDLE->READ->WRITE->RESP (read-modify-write).
REQ-026 SHALL, for an SB/SH store, latch the old word in READ and in WRITE drive the old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
REQ-027 SHALL, for an SB/SH store, pulse resp_valid at T+3.
REQ-028 SHALL hold mem_addr at the latched word index from READ through WRITE.
REQ-029 SHALL assert mem_write_enable only in WRITE and never while rst=1.
REQ-030 SHALL keep mem_write_data at 0 outside WRITE.
REQ-031 SHALL return resp_rdata=0 and resp_error=0 for successful stores.
REQ-032 SHALL give resp_valid no backpressure: one cycle, then RESP->IDLE.
REQ-033 SHALL accept a new request in the cycle after RESP, so back-to-back loads complete every 3 cycles.
REQ-034 SHALL ignore req_valid in any state other than IDLE.
REQ-035 SHALL hold resp_rdata and resp_error stable from RESP until the next resp_valid.
REQ-036 SHALL ignore addr bits above the memory index; address wrap is the memory's concern.

Reset
REQ-037 SHALL, on rst=1 at a rising edge, force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=0, mem_addr=0 and mem_write_data=0.
REQ-038 SHALL abort any in-flight access on reset, with no partial write and no response pulse.

Verification
REQ-039 SHALL cover: memory word 5 = 0x8899AABB; LB addr 0x15 -> resp_rdata 0xFFFFFFAA at T+2; LBU -> 0x000000AA; LH addr 0x16 -> 0xFFFF8899.
REQ-040 SHALL cover: SB wdata 0x123456CC to addr 0x15 over 0x8899AABB -> word becomes 0x8899CCBB, resp_valid at T+3, exactly one write strobe.
REQ-041 SHALL cover: SW 0xDEADBEEF to addr 0x20 -> mem_addr 8, mem_write_enable at T+1, resp at T+2; LW back returns 0xDEADBEEF.
REQ-042 SHALL cover: LW addr 0x22 and SH addr 0x13 -> resp_error=1 at T+1, memory unchanged, no mem_write_enable.
REQ-043 SHALL cover: rst asserted during READ of an SH -> no write strobe, no resp_valid, req_ready=1 the next cycle.
REQ-044 SHALL cover: req_valid held high continuously with back-to-back loads -> each accepted only in IDLE, resp_valid pulses spaced 3 cycles apart.

Source files
------------

// File: rtl/load_store_unit32.sv
// Byte/halfword/word load-store unit between a core request port and a
// single-cycle-read word memory; sub-word stores use read-modify-write.
module load_store_unit32 #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    output logic [n-1:0] resp_rdata,
    output logic         resp_error,
    output logic         mem_write_enable,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_write_data,
    input  logic [n-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic f_access_error(input logic we, input logic [2:0] f3,
                                            input logic [1:0] a);
        logic err;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = a[0];
            3'b010:  err = (a != 2'b00);
            3'b100:  err = we;
            3'b101:  err = we | a[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [n-1:0] f_load_extract(input logic [n-1:0] word,
                                                    input logic [1:0] a,
                                                    input logic [2:0] f3);
        logic [n-1:0] lane_b;
        logic [n-1:0] lane_h;
        logic [n-1:0] res;
        lane_b = word >> {a, 3'b000};
        lane_h = word >> {a[1], 4'b0000};
        case (f3)
            3'b000:  res = {{(n-8){lane_b[7]}}, lane_b[7:0]};
            3'b001:  res = {{(n-16){lane_h[15]}}, lane_h[15:0]};
            3'b010:  res = word;
            3'b100:  res = {{(n-8){1'b0}}, lane_b[7:0]};
            3'b101:  res = {{(n-16){1'b0}}, lane_h[15:0]};
            default: res = {n{1'b0}};
        endcase
        return res;
    endfunction

    // Replace only the addressed byte or halfword lane of the old word.
    function automatic logic [n-1:0] f_store_merge(input logic [n-1:0] old_word,
                                                   input logic [1:0] a,
                                                   input logic [2:0] f3,
                                                   input logic [n-1:0] wdata);
        logic [n-1:0] mask;
        logic [4:0]   shamt;
        case (f3[1:0])
            2'b00: begin
                mask  = {{(n-8){1'b0}}, 8'hFF};
                shamt = {a, 3'b000};
            end
            2'b01: begin
                mask  = {{(n-16){1'b0}}, 16'hFFFF};
                shamt = {a[1], 4'b0000};
            end
            default: begin
                mask  = {n{1'b1}};
                shamt = 5'd0;
            end
        endcase
        return (old_word & ~(mask << shamt)) | ((wdata & mask) << shamt);
    endfunction

    state_t       r_state;
    state_t       w_state_next;
    logic         r_we;
    logic [2:0]   r_funct3;
    logic [1:0]   r_addr_lo;
    logic [n-1:0] r_wdata;
    logic         r_req_ready;
    logic         r_resp_valid;
    logic [n-1:0] r_resp_rdata;
    logic         r_resp_error;
    logic         r_mem_we;
    logic [n-1:0] r_mem_addr;
    logic [n-1:0] r_mem_wdata;
    logic         w_accept;
    logic         w_req_error;
    logic [n-1:0] w_store_word;
    logic [n-1:0] w_resp_rdata;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_req_error = f_access_error(req_we, req_funct3, req_addr[1:0]);

    // Next-state decode: errors respond directly, SW skips the read, SB/SH read first.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!req_valid) begin
                    w_state_next = S_IDLE;
                end else if (w_req_error) begin
                    w_state_next = S_RESP;
                end else if (req_we && (req_funct3 == 3'b010)) begin
                    w_state_next = S_WRITE;
                end else begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (r_we) begin
                    w_state_next = S_WRITE;
                end else begin
                    w_state_next = S_RESP;
                end
            end
            S_WRITE: w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Write word and load result, computed one cycle ahead of their registers.
    always_comb begin
        w_store_word = {n{1'b0}};
        w_resp_rdata = {n{1'b0}};
        if (r_state == S_IDLE) begin
            w_store_word = req_wdata;
        end else begin
            w_store_word = f_store_merge(mem_read_data, r_addr_lo, r_funct3, r_wdata);
        end
        if ((r_state == S_READ) && !r_we) begin
            w_resp_rdata = f_load_extract(mem_read_data, r_addr_lo, r_funct3);
        end else begin
            w_resp_rdata = {n{1'b0}};
        end
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_wdata      <= {n{1'b0}};
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= {n{1'b0}};
            r_resp_error <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {n{1'b0}};
            r_mem_wdata  <= {n{1'b0}};
        end else begin
            r_state      <= w_state_next;
            r_req_ready  <= (w_state_next == S_IDLE);
            r_resp_valid <= (w_state_next == S_RESP);
            r_mem_we     <= (w_state_next == S_WRITE);
            r_mem_wdata  <= (w_state_next == S_WRITE) ? w_store_word : {n{1'b0}};
            if (w_accept) begin
                r_we       <= req_we;
                r_funct3   <= req_funct3;
                r_addr_lo  <= req_addr[1:0];
                r_wdata    <= req_wdata;
                r_mem_addr <= {2'b00, req_addr[n-1:2]};
            end
            if (w_state_next == S_RESP) begin
                r_resp_rdata <= w_resp_rdata;
                r_resp_error <= (r_state == S_IDLE);
            end
        end
    end

    assign req_ready        = r_req_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_rdata       = r_resp_rdata;
    assign resp_error       = r_resp_error;
    // Gate with rst so a reset arriving mid-cycle cannot leave a strobe up.
    assign mem_write_enable = r_mem_we && !rst;
    assign mem_addr         = r_mem_addr;
    assign mem_write_data   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit32.sv
// Self-checking bench for load_store_unit32: directed table, corner sequences
// and randomized accesses against a byte-array reference model.
module tb_load_store_unit32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    bit [7:0]    ref_bytes [256];
    logic [31:0] tb_mem [64];
    bit          mem_load = 1'b0;

    always #5 clk = ~clk;

    load_store_unit32 #(.n(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    function automatic bit [31:0] ref_word(int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    assign mem_read_data = tb_mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= ref_word(i);
        end else if (mem_write_enable) begin
            tb_mem[mem_addr[5:0]] <= mem_write_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, plain arithmetic.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, output bit [31:0] rdata,
                         output bit err, output int lat, output int writes);
        int size;
        bit [63:0] val;
        case (f3[1:0])
            2'd0: size = 1;
            2'd1: size = 2;
            2'd2: size = 4;
            default: size = 0;
        endcase
        err = (size == 0) || (f3[2] && size == 4) || (we && f3[2]);
        if (!err && (addr % size) != 0) err = 1'b1;
        rdata = 32'h0; writes = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            val = 64'h0;
            for (int i = 0; i < size; i++)
                val = val | (64'(ref_bytes[8'(addr + 32'(i))]) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1]) val = val - (64'd1 << (8 * size));
            rdata = val[31:0];
        end else begin
            lat = (size == 4) ? 2 : 3;
            writes = 1;
            for (int i = 0; i < size; i++)
                ref_bytes[8'(addr + 32'(i))] = 8'(wdata >> (8 * i));
        end
    endtask

    // Issue one access, watch strobes and the response within a bounded window.
    task automatic run_access(input string nm, input bit we, input bit [2:0] f3,
                              input bit [31:0] addr, input bit [31:0] wdata,
                              input bit [31:0] exp_rdata, input bit exp_err,
                              input int exp_lat, input int exp_writes);
        int lat = 0, writes = 0, wcyc = 0;
        @(negedge clk);
        chk({nm, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1);
        req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                writes++; wcyc = k;
                chk({nm, " mem_addr"}, mem_addr, {2'b00, addr[31:2]});
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " error"}, {31'h0, resp_error}, {31'h0, exp_err});
        chk({nm, " rdata"}, resp_rdata, exp_rdata);
        chk({nm, " strobes"}, 32'(writes), 32'(exp_writes));
        if (writes > 0) chk({nm, " write cycle"}, 32'(wcyc), 32'(exp_lat - 1));
        chk({nm, " wdata idle"}, mem_write_data, 32'h0);
        chk({nm, " mem word"}, tb_mem[addr[7:2]], ref_word(int'(addr[7:2])));
    endtask

    typedef struct {
        string     nm;
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_err;
        int        exp_lat;
        int        exp_writes;
    } vec_t;

    vec_t vecs [15];

    initial begin
        bit [31:0] m_rdata;
        bit        m_err;
        int        m_lat, m_writes, pulses;

        vecs[0]  = '{"LB 0x15",   1'b0, 3'b000, 32'h15, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0};
        vecs[1]  = '{"LBU 0x15",  1'b0, 3'b100, 32'h15, 32'h0,        32'h000000AA, 1'b0, 2, 0};
        vecs[2]  = '{"LH 0x16",   1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFF8899, 1'b0, 2, 0};
        vecs[3]  = '{"LHU 0x14",  1'b0, 3'b101, 32'h14, 32'h0,        32'h0000AABB, 1'b0, 2, 0};
        vecs[4]  = '{"SB 0x15",   1'b1, 3'b000, 32'h15, 32'h123456CC, 32'h0,        1'b0, 3, 1};
        vecs[5]  = '{"LW 0x14",   1'b0, 3'b010, 32'h14, 32'h0,        32'h8899CCBB, 1'b0, 2, 0};
        vecs[6]  = '{"SW 0x20",   1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        vecs[7]  = '{"LW 0x20",   1'b0, 3'b010, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[8]  = '{"LW 0x22",   1'b0, 3'b010, 32'h22, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[9]  = '{"SH 0x13",   1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0,        1'b1, 1, 0};
        vecs[10] = '{"S f3=100",  1'b1, 3'b100, 32'h20, 32'h11111111, 32'h0,        1'b1, 1, 0};
        vecs[11] = '{"L f3=011",  1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[12] = '{"SH 0x22",   1'b1, 3'b001, 32'h22, 32'hAAAA1234, 32'h0,        1'b0, 3, 1};
        vecs[13] = '{"LW 0x20 b", 1'b0, 3'b010, 32'h20, 32'h0,        32'h1234BEEF, 1'b0, 2, 0};
        vecs[14] = '{"LB 0x23",   1'b0, 3'b000, 32'h23, 32'h0,        32'h00000012, 1'b0, 2, 0};

        for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);
        {ref_bytes[23], ref_bytes[22], ref_bytes[21], ref_bytes[20]} = 32'h8899AABB;
        {ref_bytes[35], ref_bytes[34], ref_bytes[33], ref_bytes[32]} = 32'h01020304;

        rst = 1'b1; mem_load = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_error", {31'h0, resp_error}, 32'h0);
        chk("reset mem_we", {31'h0, mem_write_enable}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_write_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; mem_load = 1'b0;

        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                  m_rdata, m_err, m_lat, m_writes);
            run_access(vecs[i].nm, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_writes);
        end

        // Reset while an SH sits in READ: no strobe, no response, ready next cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h30; req_wdata = 32'h00005555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstREAD mem_we in READ", {31'h0, mem_write_enable}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstREAD req_ready", {31'h0, req_ready}, 32'h1);
        chk("rstREAD resp_rdata", resp_rdata, 32'h0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_write_enable || resp_valid) pulses++;
            @(negedge clk);
        end
        chk("rstREAD activity", 32'(pulses), 32'h0);
        chk("rstREAD mem word", tb_mem[12], ref_word(12));

        // req_valid held high: loads accepted only from IDLE, responses every 3 cycles.
        model(1'b0, 3'b010, 32'h20, 32'h0, m_rdata, m_err, m_lat, m_writes);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("b2b valid c%0d", c), {31'h0, resp_valid}, {31'h0, (c % 3) == 2});
            if (resp_valid) chk($sformatf("b2b rdata c%0d", c), resp_rdata, m_rdata);
        end
        req_valid = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 80; i++) begin
            bit        r_we;
            bit [2:0]  r_f3;
            bit [31:0] r_addr, r_wd;
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr[1:0] = (r_f3[1:0] == 2'd2) ? 2'd0 : {r_addr[1], 1'b0};
            r_wd = $urandom;
            model(r_we, r_f3, r_addr, r_wd, m_rdata, m_err, m_lat, m_writes);
            run_access($sformatf("rand%0d", i), r_we, r_f3, r_addr, r_wd,
                       m_rdata, m_err, m_lat, m_writes);
        end

        for (int w = 0; w < 64; w++) chk($sformatf("final word %0d", w), tb_mem[w], ref_word(w));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
